// File: rtl/lsu_subword.sv
// ---------------------------------------------------------------------------
// lsu_subword
//
// Load/store unit sitting between the execute stage and a word-wide,
// byte-addressed data memory. Decodes RV32I load/store funct3, only ever
// presents word-aligned addresses to memory, sign/zero-extends sub-word
// loads and performs sub-word stores as read-modify-write.
// Misaligned, out-of-range or illegal-funct3 requests are answered with an
// error response and never touch memory.
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   req_valid      core request present
//   req_ready      high only when idle; accept = req_valid && req_ready
//   req_we         1 = store, 0 = load
//   req_funct3     RV32I funct3 (B, H, W, BU, HU)
//   req_addr       byte address
//   req_wdata      store data (low byte/half used for SB/SH)
//   resp_valid     one-cycle response pulse
//   resp_rdata     extended load data (0 for stores and errors)
//   resp_err       error flag, valid with resp_valid
//   mem_addr       word-aligned memory address
//   mem_we         memory write enable
//   mem_wdata      full little-endian word to write
//   mem_rdata      combinational read data for mem_addr
// ---------------------------------------------------------------------------
module lsu_subword #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        err_q;

    logic        bad_f3;
    logic        misalign;
    logic        out_of_range;
    logic        req_err;
    logic [32:0] last_byte;
    logic [31:0] store_word;
    logic [31:0] load_data;

    // Classify the incoming request. Loads allow B/H/W/BU/HU, stores only
    // B/H/W. The range check uses a 33-bit sum so addresses near 2^32
    // cannot wrap around and look legal.
    always_comb begin
        if (req_we) begin
            bad_f3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        last_byte    = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
        out_of_range = last_byte >= 33'(MEM_BYTES);
        req_err      = bad_f3 || misalign || out_of_range;
    end

    // Main sequencer. A request is latched in IDLE and then walks through
    // RD (fetch the word for loads and sub-word stores), WR (write the
    // merged or full word) and RESP. Errors jump straight to RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        f3_q    <= req_funct3;
                        we_q    <= req_we;
                        err_q   <= req_err;
                        if (req_err) begin
                            state <= RESP;
                        end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    buf_q <= mem_rdata;
                    state <= we_q ? WR : RESP;
                end
                WR:      state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Build the word written back: sub-word stores overwrite one lane of
    // the buffered word, SW writes its data unchanged.
    always_comb begin
        store_word = buf_q;
        case (f3_q[1:0])
            2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    // Pick the addressed lane out of the buffered word and extend it.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = buf_q[{addr_q[1:0], 3'b000} +: 8];
        lane_h = buf_q[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_data = {24'd0, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = buf_q;
        endcase
    end

    // Outputs depend on state only. mem_we is also gated by rst so a reset
    // landing on the WR edge keeps memory from capturing the write.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = ((state == RESP) && !err_q && !we_q) ? load_data : 32'd0;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_we     = (state == WR) && rst;
        mem_wdata  = (state == WR) ? store_word : 32'd0;
    end

endmodule

// File: tb/tb_lsu_subword.sv
// ---------------------------------------------------------------------------
// tb_lsu_subword
//
// Self-checking bench for lsu_subword. A behavioural byte-array model of
// memory predicts every response, latency and written word; a separate
// word array acts as the real memory the DUT talks to.
// ---------------------------------------------------------------------------
module tb_lsu_subword;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic [7:0]  refMem [0:MEM_BYTES-1];

    int checks = 0;
    int passes = 0;
    int accepts = 0;

    lsu_subword #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory seen by the DUT, plus a count of accepted requests.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        if (rst && req_valid && req_ready) accepts <= accepts + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    endtask

    task automatic presetWord(input int idx, input logic [31:0] v);
        mem[idx] = v;
        for (int i = 0; i < 4; i++) refMem[idx*4 + i] = v[8*i +: 8];
    endtask

    function automatic logic [31:0] refWord(input longint base);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = refMem[base + i];
        return w;
    endfunction

    // Reference: what an access should do, from access size and RV32I rules.
    task automatic refAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic err,
                             output logic [31:0] rdata, output int lat);
        int nbytes;
        longint a;
        longint val;
        a = longint'(addr);
        case (f3)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            3'd2:       nbytes = 4;
            default:    nbytes = 0;
        endcase
        if (we && f3 > 3'd2) nbytes = 0;
        if (nbytes == 0) err = 1'b1;
        else err = ((a % nbytes) != 0) || ((a - (a % 4)) + 3 >= MEM_BYTES);
        rdata = 32'd0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < nbytes; i++) refMem[a + i] = wdata[8*i +: 8];
            lat = (nbytes == 4) ? 2 : 3;
        end else begin
            val = 0;
            for (int i = 0; i < nbytes; i++) val += longint'(refMem[a + i]) << (8*i);
            if (!f3[2] && nbytes < 4 && ((val >> (8*nbytes - 1)) & 1) == 1)
                val -= (longint'(1) << (8*nbytes));
            rdata = val[31:0];
            lat = 2;
        end
    endtask

    // Issue one request, follow it to its response and check everything.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        logic        expErr;
        logic [31:0] expData;
        int          expLat;
        int          lat;
        int          weCycles;
        int          readyBusy;
        logic [31:0] weAddr;
        logic [31:0] weData;
        logic [31:0] gotData;
        logic        gotErr;
        longint      base;
        refAccess(we, f3, addr, wdata, expErr, expData, expLat);
        lat = 0; weCycles = 0; readyBusy = 0;
        weAddr = 32'd0; weData = 32'd0; gotData = 32'hxxxxxxxx; gotErr = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (int g = 0; g < 10 && !req_ready; g++) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (mem_we) begin
                weCycles++;
                weAddr = mem_addr;
                weData = mem_wdata;
            end
            if (req_ready) readyBusy++;
            if (resp_valid) begin
                lat = n;
                gotData = resp_rdata;
                gotErr = resp_err;
                break;
            end
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("resp_err", 32'(gotErr), 32'(expErr));
        checkOutput("resp_rdata", gotData, expData);
        checkOutput("ready_busy", 32'(readyBusy), 32'd0);
        checkOutput("we_cycles", 32'(weCycles), (we && !expErr) ? 32'd1 : 32'd0);
        if (we && !expErr) begin
            base = longint'(addr) - (longint'(addr) % 4);
            checkOutput("wr_addr", weAddr, 32'(base));
            checkOutput("wr_data", weData, refWord(base));
            checkOutput("mem_word", mem[base / 4], refWord(base));
        end
        @(negedge clk);
        checkOutput("pulse_end", {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        logic        e;
        logic [31:0] d;
        int          l;
        int          a0;
        for (int i = 0; i < 256; i++) presetWord(i, $urandom);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_outs", {29'd0, resp_valid, resp_err, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_rdata_wdata", resp_rdata | mem_wdata, 32'd0);
        rst = 1'b1;

        // SW over a known word, then SB + read-back.
        presetWord(4, 32'h11223344);
        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        presetWord(4, 32'h11223344);
        applyStimulus(1'b1, 3'd0, 32'h13, 32'h000000AA);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'd0);

        // Extension cases.
        presetWord(4, 32'h80FF7F01);
        applyStimulus(1'b0, 3'd0, 32'h12, 32'd0);
        applyStimulus(1'b0, 3'd4, 32'h12, 32'd0);
        applyStimulus(1'b0, 3'd1, 32'h12, 32'd0);
        applyStimulus(1'b0, 3'd5, 32'h10, 32'd0);
        applyStimulus(1'b0, 3'd0, 32'h10, 32'd0);

        // Error cases.
        applyStimulus(1'b0, 3'd2, 32'h11, 32'd0);
        applyStimulus(1'b1, 3'd1, 32'h13, 32'h1234);
        applyStimulus(1'b0, 3'd0, 32'h400, 32'd0);
        applyStimulus(1'b0, 3'd3, 32'h10, 32'd0);
        applyStimulus(1'b0, 3'd2, 32'h3FC, 32'd0);
        applyStimulus(1'b1, 3'd4, 32'h10, 32'd0);

        // Reset landing on the WR edge of an SH.
        presetWord(4, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h12; req_wdata = 32'h5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        checkOutput("sh_rd_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        checkOutput("sh_wr_we_before_rst", 32'(mem_we), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("sh_wr_we_in_rst", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("sh_rst_ready", 32'(req_ready), 32'd1);
        checkOutput("sh_rst_outs", {29'd0, resp_valid, resp_err, mem_we}, 32'd0);
        checkOutput("sh_rst_mem_addr", mem_addr, 32'd0);
        checkOutput("sh_rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("sh_mem_unchanged", mem[4], refWord(16));
        l = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) l++;
        end
        checkOutput("sh_no_resp", 32'(l), 32'd0);

        // Two back-to-back requests with req_valid held high.
        a0 = accepts;
        refAccess(1'b0, 3'd2, 32'h10, 32'd0, e, d, l);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("q_rd_ready", {30'd0, req_ready, resp_valid}, 32'd0);
        @(negedge clk);
        checkOutput("q_resp1", {30'd0, req_ready, resp_valid}, 32'd1);
        checkOutput("q_rdata1", resp_rdata, d);
        @(negedge clk);
        checkOutput("q_idle_ready", 32'(req_ready), 32'd1);
        checkOutput("q_accepts1", 32'(accepts - a0), 32'd1);
        refAccess(1'b1, 3'd2, 32'h14, 32'hCAFEF00D, e, d, l);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        checkOutput("q_wr", {30'd0, req_ready, mem_we}, 32'd1);
        @(negedge clk);
        checkOutput("q_resp2", {30'd0, req_ready, resp_valid}, 32'd1);
        checkOutput("q_mem_word", mem[5], refWord(20));
        @(negedge clk);
        checkOutput("q_accepts2", 32'(accepts - a0), 32'd2);

        // Randomized traffic, mostly in range with some far-off addresses.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = 32'($urandom_range(0, MEM_BYTES + 7));
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
